// File: rtl/ahb_master_port.sv
// Single-outstanding AHB-Lite initiator: arbitrates core fetch and load/store requests,
// decodes ROM/RAM, rejects misaligned/unmapped/ROM-store accesses and bounds wait states.
module ahb_master_port #(
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] ROM_MASK = 32'hFFFF_0000,
    parameter logic [31:0] RAM_BASE = 32'h1000_0000,
    parameter logic [31:0] RAM_MASK = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_addr,
    output logic        ifetch_ack,
    output logic [31:0] ifetch_rdata,
    output logic        ifetch_err,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [2:0]  dmem_size,
    input  logic        dmem_signed,
    output logic        dmem_ack,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    output logic        is_signed,
    output logic        HSEL1,
    output logic        HSEL2,
    output logic        muxsel,
    input  logic [31:0] instruction,
    input  logic [31:0] load_out,
    input  logic        hready_inst,
    input  logic        hready_data,
    input  logic        hresp_inst,
    input  logic        hresp_data
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    state_t         state, state_nxt;
    logic [31:0]    req_addr, req_addr_nxt;
    logic [31:0]    req_wdata, req_wdata_nxt;
    logic [2:0]     req_size, req_size_nxt;
    logic           req_we, req_we_nxt;
    logic           req_signed, req_signed_nxt;
    logic           req_data, req_data_nxt;
    logic           sel_ram, sel_ram_nxt;
    logic           last_data, last_data_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;

    logic           fetch_ok, data_ok, grant_data;
    logic [31:0]    cand_addr;
    logic [2:0]     cand_size;
    logic           cand_we;
    logic           hit_rom, hit_ram, misaligned;
    logic           hready_sel, hresp_sel;
    logic           done, done_err, done_data;
    logic [31:0]    done_rdata;
    logic           active;

    // No new request is taken while any completion pulse is out, so starts are >= 4 cycles apart.
    always_comb begin
        fetch_ok   = ifetch_req && !ifetch_ack && !dmem_ack;
        data_ok    = dmem_req && !ifetch_ack && !dmem_ack;
        grant_data = data_ok && (!fetch_ok || !last_data);
        cand_addr  = grant_data ? dmem_addr : ifetch_addr;
        cand_size  = grant_data ? dmem_size : 3'b010;
        cand_we    = grant_data && dmem_we;
        hit_rom    = (cand_addr & ROM_MASK) == ROM_BASE;
        hit_ram    = (cand_addr & RAM_MASK) == RAM_BASE;
        case (cand_size)
            3'b000:  misaligned = 1'b0;
            3'b001:  misaligned = cand_addr[0];
            3'b010:  misaligned = cand_addr[1:0] != 2'b00;
            default: misaligned = 1'b1;
        endcase
        hready_sel = sel_ram ? hready_data : hready_inst;
        hresp_sel  = sel_ram ? hresp_data : hresp_inst;
    end

    // NOTE: every signal written here gets a default first, otherwise synthesis infers latches.
    always_comb begin
        state_nxt      = state;
        req_addr_nxt   = req_addr;
        req_wdata_nxt  = req_wdata;
        req_size_nxt   = req_size;
        req_we_nxt     = req_we;
        req_signed_nxt = req_signed;
        req_data_nxt   = req_data;
        sel_ram_nxt    = sel_ram;
        last_data_nxt  = last_data;
        wait_cnt_nxt   = wait_cnt;
        done           = 1'b0;
        done_err       = 1'b0;
        done_data      = req_data;
        done_rdata     = '0;
        case (state)
            IDLE: begin
                if (fetch_ok || data_ok) begin
                    last_data_nxt = grant_data;
                    if (misaligned || !(hit_rom || hit_ram) || (hit_rom && cand_we)) begin
                        done      = 1'b1;
                        done_err  = 1'b1;
                        done_data = grant_data;
                    end else begin
                        req_addr_nxt   = cand_addr;
                        req_wdata_nxt  = grant_data ? dmem_wdata : '0;
                        req_size_nxt   = cand_size;
                        req_we_nxt     = cand_we;
                        req_signed_nxt = grant_data && dmem_signed;
                        req_data_nxt   = grant_data;
                        sel_ram_nxt    = !hit_rom;
                        wait_cnt_nxt   = '0;
                        state_nxt      = ADDR;
                    end
                end
            end
            ADDR: state_nxt = DATA;
            DATA, ERR: begin
                if (hready_sel) begin
                    done       = 1'b1;
                    done_err   = hresp_sel || (state == ERR);
                    done_rdata = (done_err || req_we) ? '0 : (sel_ram ? load_out : instruction);
                    state_nxt  = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    done      = 1'b1;
                    done_err  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                    if (hresp_sel) state_nxt = ERR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr     <= '0;
            req_wdata    <= '0;
            req_size     <= '0;
            req_we       <= 1'b0;
            req_signed   <= 1'b0;
            req_data     <= 1'b0;
            sel_ram      <= 1'b0;
            last_data    <= 1'b0;
            wait_cnt     <= '0;
            ifetch_ack   <= 1'b0;
            ifetch_err   <= 1'b0;
            ifetch_rdata <= '0;
            dmem_ack     <= 1'b0;
            dmem_err     <= 1'b0;
            dmem_rdata   <= '0;
        end else begin
            req_addr     <= req_addr_nxt;
            req_wdata    <= req_wdata_nxt;
            req_size     <= req_size_nxt;
            req_we       <= req_we_nxt;
            req_signed   <= req_signed_nxt;
            req_data     <= req_data_nxt;
            sel_ram      <= sel_ram_nxt;
            last_data    <= last_data_nxt;
            wait_cnt     <= wait_cnt_nxt;
            ifetch_ack   <= done && !done_data;
            ifetch_err   <= done_err && !done_data;
            ifetch_rdata <= done_data ? '0 : done_rdata;
            dmem_ack     <= done && done_data;
            dmem_err     <= done_err && done_data;
            dmem_rdata   <= done_data ? done_rdata : '0;
        end
    end

    // Bus side is decoded from the state register so reset clears it without waiting for a clock.
    always_comb begin
        active    = state != IDLE;
        htrans    = (state == ADDR) ? 2'b10 : 2'b00;
        haddr     = active ? req_addr : '0;
        hwrite    = active && req_we;
        hsize     = active ? req_size : 3'b000;
        hprot     = active ? {3'b001, req_data} : 4'b0000;
        is_signed = active && req_signed;
        HSEL1     = active && !sel_ram;
        HSEL2     = active && sel_ram;
        muxsel    = active && sel_ram;
        hwdata    = (((state == DATA) || (state == ERR)) && req_we) ? req_wdata : '0;
    end

endmodule

// File: tb/tb_ahb_master_port.sv
// Directed and randomized bench for ahb_master_port; expectations come from a
// transaction-level model of decode, arbitration, latency and error rules.
module tb_ahb_master_port;

    localparam logic [31:0] ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] ROM_MASK = 32'hFFFF_0000;
    localparam logic [31:0] RAM_BASE = 32'h1000_0000;
    localparam logic [31:0] RAM_MASK = 32'hFFFF_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifetch_req, ifetch_ack, ifetch_err;
    logic [31:0] ifetch_addr, ifetch_rdata;
    logic        dmem_req, dmem_we, dmem_signed, dmem_ack, dmem_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [2:0]  dmem_size;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite, is_signed, HSEL1, HSEL2, muxsel;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] instruction, load_out;
    logic        hready_inst, hready_data, hresp_inst, hresp_data;

    int checks;
    int errors;
    bit last_data_m;

    ahb_master_port #(
        .ROM_BASE(ROM_BASE), .ROM_MASK(ROM_MASK),
        .RAM_BASE(RAM_BASE), .RAM_MASK(RAM_MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_ack(ifetch_ack),
        .ifetch_rdata(ifetch_rdata), .ifetch_err(ifetch_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_size(dmem_size), .dmem_signed(dmem_signed), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
        .hwdata(hwdata), .is_signed(is_signed), .HSEL1(HSEL1), .HSEL2(HSEL2), .muxsel(muxsel),
        .instruction(instruction), .load_out(load_out),
        .hready_inst(hready_inst), .hready_data(hready_data),
        .hresp_inst(hresp_inst), .hresp_data(hresp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          bus;
        bit          ram;
        bit          err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Outcome of one request: lat counts clock edges from the sampling edge to the edge raising ack.
    function automatic exp_t model(input bit we, input logic [31:0] addr, input logic [2:0] size,
                                   input int waits, input bit bad_resp, input logic [31:0] rdv);
        exp_t e;
        bit rom, ram, mis;
        rom = (addr & ROM_MASK) == ROM_BASE;
        ram = (addr & RAM_MASK) == RAM_BASE;
        mis = (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00) || size > 3'd2;
        e.ram = !rom && ram;
        e.bus = !mis && (rom || ram) && !(rom && we);
        if (!e.bus) begin
            e.err = 1'b1; e.rdata = '0; e.lat = 1;
        end else if (waits >= TIMEOUT) begin
            e.err = 1'b1; e.rdata = '0; e.lat = 2 + TIMEOUT;
        end else begin
            e.err = bad_resp; e.rdata = (bad_resp || we) ? 32'h0 : rdv; e.lat = 3 + waits;
        end
        return e;
    endfunction

    task automatic set_idle_slaves();
        hready_inst = 1'b1; hready_data = 1'b1; hresp_inst = 1'b0; hresp_data = 1'b0;
    endtask

    // One request on one channel; called at a negedge with the port idle.
    task automatic txn(input string tag, input bit dch, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size, input bit sgn,
                       input int waits, input bit bad_resp, input logic [31:0] rdv);
        exp_t        e;
        logic [2:0]  sz;
        bit          w, rdy, rsp;
        int          lat, n_addr, data_bad, other_acks;
        logic        got_err;
        logic [31:0] got_rdata;
        logic [43:0] exp_ap, ap;
        sz = dch ? size : 3'd2;
        w  = dch && we;
        e  = model(w, addr, sz, waits, bad_resp, rdv);
        last_data_m = dch;
        exp_ap = {addr, w, sz, 3'b001, dch, !e.ram, e.ram, e.ram, dch && sgn};
        lat = -1; n_addr = 0; data_bad = 0; other_acks = 0;
        got_err = 1'bx; got_rdata = 'x;
        instruction = e.ram ? ~rdv : rdv;
        load_out    = e.ram ? rdv : ~rdv;
        if (dch) begin
            dmem_req = 1'b1; dmem_we = w; dmem_addr = addr; dmem_wdata = wdata;
            dmem_size = sz; dmem_signed = sgn;
        end else begin
            ifetch_req = 1'b1; ifetch_addr = addr;
        end
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (htrans == 2'b10) begin
                n_addr++;
                ap = {haddr, hwrite, hsize, hprot, HSEL1, HSEL2, muxsel, is_signed};
                check({tag, "/addr_phase"}, 64'(ap), 64'(exp_ap));
            end
            if (e.bus && c >= 2 && c < e.lat &&
                (hwdata !== (w ? wdata : 32'h0) || HSEL1 !== !e.ram || HSEL2 !== e.ram ||
                 muxsel !== e.ram || htrans !== 2'b00 || haddr !== addr))
                data_bad++;
            if ((dch ? dmem_ack : ifetch_ack) === 1'b1) begin
                lat       = c;
                got_err   = dch ? dmem_err : ifetch_err;
                got_rdata = dch ? dmem_rdata : ifetch_rdata;
                if (dch) dmem_req = 1'b0; else ifetch_req = 1'b0;
            end
            if ((dch ? ifetch_ack : dmem_ack) === 1'b1) other_acks++;
            rdy = 1'b1; rsp = 1'b0;
            if (e.bus && c >= 2 && lat < 0) begin
                rdy = (c - 2) >= waits;
                rsp = bad_resp;
            end
            // The unselected slave always shows the opposite ready and no error.
            hready_inst = e.ram ? !rdy : rdy;
            hready_data = e.ram ? rdy : !rdy;
            hresp_inst  = e.ram ? 1'b0 : rsp;
            hresp_data  = e.ram ? rsp : 1'b0;
        end
        if (lat < 0) begin
            if (dch) dmem_req = 1'b0; else ifetch_req = 1'b0;
        end
        check({tag, "/latency"}, 64'(lat), 64'(e.lat));
        check({tag, "/err"}, 64'(got_err), 64'(e.err));
        check({tag, "/rdata"}, 64'(got_rdata), 64'(e.rdata));
        check({tag, "/addr_phases"}, 64'(n_addr), 64'(e.bus ? 1 : 0));
        check({tag, "/data_phase_bad"}, 64'(data_bad), 64'(0));
        check({tag, "/other_ack"}, 64'(other_acks), 64'(0));
        set_idle_slaves();
        @(negedge clk);
        check({tag, "/ack_pulse"}, 64'({ifetch_ack, dmem_ack}), 64'(0));
    endtask

    // Fetch and load raised together; the channel not granted last must go first.
    task automatic dual(input string tag);
        bit          exp_first_data;
        int          first_ch, second_ch, n_acks, first_mux;
        logic [31:0] f_rd, d_rd;
        exp_first_data = !last_data_m;
        instruction = 32'h0000_0093; load_out = 32'hCAFE_F00D;
        set_idle_slaves();
        ifetch_req = 1'b1; ifetch_addr = 32'h0000_0020;
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h1000_0010;
        dmem_size = 3'd2; dmem_signed = 1'b0;
        first_ch = -1; second_ch = -1; n_acks = 0; first_mux = -1;
        f_rd = 'x; d_rd = 'x;
        for (int c = 1; c <= 40 && n_acks < 2; c++) begin
            @(negedge clk);
            if (htrans == 2'b10 && first_mux < 0) first_mux = int'(muxsel);
            if (dmem_ack === 1'b1) begin
                d_rd = dmem_rdata; dmem_req = 1'b0; n_acks++;
                if (first_ch < 0) first_ch = 1; else second_ch = 1;
            end
            if (ifetch_ack === 1'b1) begin
                f_rd = ifetch_rdata; ifetch_req = 1'b0; n_acks++;
                if (first_ch < 0) first_ch = 0; else second_ch = 0;
            end
        end
        ifetch_req = 1'b0; dmem_req = 1'b0;
        check({tag, "/acks"}, 64'(n_acks), 64'(2));
        check({tag, "/first"}, 64'(first_ch), 64'(exp_first_data ? 1 : 0));
        check({tag, "/second"}, 64'(second_ch), 64'(exp_first_data ? 0 : 1));
        check({tag, "/first_muxsel"}, 64'(first_mux), 64'(exp_first_data ? 1 : 0));
        check({tag, "/fetch_rdata"}, 64'(f_rd), 64'(32'h0000_0093));
        check({tag, "/load_rdata"}, 64'(d_rd), 64'(32'hCAFE_F00D));
        last_data_m = !exp_first_data;
        @(negedge clk);
    endtask

    initial begin
        int stray;
        checks = 0; errors = 0; last_data_m = 1'b0;
        reset = 1'b1;
        ifetch_req = 1'b0; ifetch_addr = '0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
        dmem_size = 3'd0; dmem_signed = 1'b0;
        instruction = '0; load_out = '0;
        set_idle_slaves();
        #2;
        check("reset/core_flags", 64'({ifetch_ack, ifetch_err, dmem_ack, dmem_err}), 64'(0));
        check("reset/ifetch_rdata", 64'(ifetch_rdata), 64'(0));
        check("reset/dmem_rdata", 64'(dmem_rdata), 64'(0));
        check("reset/bus_ctrl",
              64'({htrans, HSEL1, HSEL2, muxsel, hwrite, hsize, hprot, is_signed}), 64'(0));
        check("reset/haddr_hwdata", {haddr, hwdata}, 64'(0));
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        dual("tie_from_reset");
        txn("fetch_zero_wait", 1'b0, 1'b0, 32'h0000_0010, 32'h0, 3'd2, 1'b0, 0, 1'b0, 32'h0000_0013);
        txn("store_2_waits", 1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 3'd2, 1'b0, 2, 1'b0, 32'h1234_5678);
        txn("half_misaligned", 1'b1, 1'b0, 32'h1000_0003, 32'h0, 3'd1, 1'b1, 0, 1'b0, 32'h7777_8888);
        txn("fetch_unmapped", 1'b0, 1'b0, 32'h2000_0000, 32'h0, 3'd2, 1'b0, 0, 1'b0, 32'h0000_0013);
        txn("store_to_rom", 1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_0BAD, 3'd2, 1'b0, 0, 1'b0, 32'h0);
        txn("load_err_wait", 1'b1, 1'b0, 32'h1000_0008, 32'h0, 3'd2, 1'b0, 1, 1'b1, 32'h5555_AAAA);
        txn("load_err_now", 1'b1, 1'b0, 32'h1000_0008, 32'h0, 3'd2, 1'b0, 0, 1'b1, 32'h5555_AAAA);
        txn("load_timeout", 1'b1, 1'b0, 32'h1000_000C, 32'h0, 3'd2, 1'b0, TIMEOUT + 4, 1'b0, 32'h1);
        txn("byte_load_odd", 1'b1, 1'b0, 32'h1000_0007, 32'h0, 3'd0, 1'b1, 1, 1'b0, 32'hFFFF_FF80);

        // Reset in the middle of a data phase abandons the transfer without an ack.
        load_out = 32'h1111_2222;
        hready_data = 1'b0;
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h1000_0020; dmem_size = 3'd2;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid/in_data", 64'({HSEL2, htrans}), 64'({1'b1, 2'b00}));
        #2 reset = 1'b1;
        #1;
        check("rst_mid/bus_ctrl", 64'({htrans, HSEL1, HSEL2, muxsel, hwrite}), 64'(0));
        check("rst_mid/haddr", 64'(haddr), 64'(0));
        check("rst_mid/acks", 64'({ifetch_ack, dmem_ack, ifetch_err, dmem_err}), 64'(0));
        check("rst_mid/rdata", {ifetch_rdata, dmem_rdata}, 64'(0));
        dmem_req = 1'b0;
        set_idle_slaves();
        @(negedge clk);
        reset = 1'b0;
        last_data_m = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (ifetch_ack === 1'b1 || dmem_ack === 1'b1) stray++;
        end
        check("rst_mid/no_late_ack", 64'(stray), 64'(0));
        txn("fetch_after_reset", 1'b0, 1'b0, 32'h0000_0104, 32'h0, 3'd2, 1'b0, 1, 1'b0, 32'h00A0_0093);

        for (int i = 0; i < 40; i++) begin
            bit          dch, we, sgn, bad;
            int          waits, r;
            logic [2:0]  sz;
            logic [31:0] addr;
            dch  = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 9));
            addr = (r < 4) ? ROM_BASE : ((r < 9) ? RAM_BASE : 32'h3000_0000);
            addr = addr | 32'($urandom_range(0, 32'hFFFF));
            sz   = dch ? 3'($urandom_range(0, 2)) : 3'd2;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 3'd2) addr = addr & ~32'h3;
                else if (sz == 3'd1) addr = addr & ~32'h1;
            end
            we    = dch && 1'($urandom_range(0, 1));
            sgn   = 1'($urandom_range(0, 1));
            waits = int'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) waits = TIMEOUT + 1;
            bad   = (waits < TIMEOUT) && ($urandom_range(0, 5) == 0);
            txn($sformatf("rand%0d", i), dch, we, addr, $urandom, sz, sgn, waits, bad, $urandom);
        end

        dual("tie_after_random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
